// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares one 256x8 register-file RAM between priority port A and port B.
// Define REGFILE_WORD_EN to enable 16-bit big-endian register-pair accesses.
module regfile_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic        a_word,
    input  logic [7:0]  a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic        b_word,
    input  logic [7:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    output logic        busy,
    output logic        ram_write_en,
    output logic [7:0]  ram_address,
    output logic [7:0]  ram_data_in,
    input  logic [7:0]  ram_data_out
);
`ifdef REGFILE_WORD_EN
    localparam logic WORD_EN = 1'b1;
`else
    localparam logic WORD_EN = 1'b0;
`endif
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, CYC0, CYC1, FIN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        port_q, port_d, we_q, we_d, word_q, word_d;
    logic [7:0]  addr_q, addr_d, hi_q, hi_d;
    logic [15:0] wdata_q, wdata_d;
    logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [15:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic        ram_we_q, ram_we_d;
    logic [7:0]  ram_addr_q, ram_addr_d, ram_din_q, ram_din_d;
    logic        grant_b, rd_fin;
    logic [15:0] rd_val;

    always_comb begin
        grant_b    = b_req & (~a_req | starve_q == LIMIT);
        rd_fin     = state_q == FIN & ~we_q;
        rd_val     = {word_q ? hi_q : 8'h00, ram_data_out};
        state_d    = state_q;
        starve_d   = b_req ? starve_q : 4'd0;
        port_d     = port_q;
        we_d       = we_q;
        word_d     = word_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hi_d       = hi_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        case (state_q)
            IDLE: if (a_req | b_req) begin
                state_d    = CYC0;
                port_d     = grant_b;
                we_d       = grant_b ? b_we : a_we;
                word_d     = (grant_b ? b_word : a_word) & WORD_EN;
                addr_d     = grant_b ? b_addr : a_addr;
                wdata_d    = grant_b ? b_wdata : a_wdata;
                starve_d   = (grant_b | ~b_req) ? 4'd0 : starve_q + 4'(starve_q != LIMIT);
                ram_we_d   = we_d;
                ram_addr_d = addr_d;
                ram_din_d  = word_d ? wdata_d[15:8] : wdata_d[7:0];
            end
            CYC0: begin
                state_d    = word_q ? CYC1 : FIN;
                ram_we_d   = word_q & we_q;
                ram_addr_d = word_q ? addr_q + 8'd1 : ram_addr_q;
                ram_din_d  = word_q ? wdata_q[7:0] : ram_din_q;
            end
            CYC1: begin
                state_d = FIN;
                hi_d    = ram_data_out;
            end
            default: begin
                state_d   = IDLE;
                a_rdata_d = (rd_fin & ~port_q) ? rd_val : a_rdata_q;
                b_rdata_d = (rd_fin & port_q) ? rd_val : b_rdata_q;
            end
        endcase
        a_ack_d = state_d == FIN & ~port_q;
        b_ack_d = state_d == FIN & port_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            starve_q   <= 4'd0;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            word_q     <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 16'h0000;
            hi_q       <= 8'h00;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= 16'h0000;
            b_rdata_q  <= 16'h0000;
            ram_we_q   <= 1'b0;
            ram_addr_q <= 8'h00;
            ram_din_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            port_q     <= port_d;
            we_q       <= we_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hi_q       <= hi_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
        end
    end

    // The registered RAM presents the final byte during FIN, so read data bypasses the holding register then.
    assign a_rdata      = (rd_fin & ~port_q) ? rd_val : a_rdata_q;
    assign b_rdata      = (rd_fin & port_q) ? rd_val : b_rdata_q;
    assign a_ack        = a_ack_q;
    assign b_ack        = b_ack_q;
    assign busy         = state_q != IDLE;
    assign ram_write_en = ram_we_q;
    assign ram_address  = ram_addr_q;
    assign ram_data_in  = ram_din_q;
endmodule
